// File: rtl/comp2_scheduler.sv
// comp2_scheduler: round-robin shared serial two's-complement negation engine
module comp2_scheduler #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             REQ0,
  input  logic             REQ1,
  input  logic [WIDTH-1:0] A0,
  input  logic [WIDTH-1:0] A1,
  output logic             GNT0,
  output logic             GNT1,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] OUT,
  output logic             OUT_ID
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d, acc_q, acc_d, out_q, out_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             seen_q, seen_d, id_q, id_d, last_q, last_d;
  logic             out_id_q, out_id_d, done_q, done_d, r;
  assign BUSY   = state_q != IDLE;
  assign DONE   = done_q;
  assign OUT    = out_q;
  assign OUT_ID = out_id_q;
  // Grant arbitration in IDLE and the bit-serial copy-until-first-one / invert-rest step
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    seen_d   = seen_q;
    id_d     = id_q;
    last_d   = last_q;
    out_d    = out_q;
    out_id_d = out_id_q;
    done_d   = 1'b0;
    r        = seen_q ? ~sr_q[0] : sr_q[0];
    GNT0     = (state_q == IDLE) && REQ0 && (!REQ1 || last_q);
    GNT1     = (state_q == IDLE) && REQ1 && !GNT0;
    case (state_q)
      IDLE: if (GNT0 || GNT1) begin
        sr_d    = GNT1 ? A1 : A0;
        id_d    = GNT1;
        last_d  = GNT1;
        cnt_d   = '0;
        seen_d  = 1'b0;
        state_d = SHIFT;
      end
      SHIFT: begin
        sr_d   = sr_q >> 1;
        seen_d = seen_q | sr_q[0];
        acc_d  = {r, acc_q[WIDTH-1:1]};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d  = FINISH;
          out_d    = acc_d;
          out_id_d = id_q;
          done_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // State registers; reset aborts any operation in flight and clears the result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sr_q     <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      seen_q   <= 1'b0;
      id_q     <= 1'b0;
      last_q   <= 1'b1;
      out_q    <= '0;
      out_id_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      seen_q   <= seen_d;
      id_q     <= id_d;
      last_q   <= last_d;
      out_q    <= out_d;
      out_id_q <= out_id_d;
      done_q   <= done_d;
    end
  end
endmodule

// File: tb/tb_comp2_scheduler.sv
// tb_comp2_scheduler: scoreboard bench for comp2_scheduler
module tb_comp2_scheduler;
  logic       clk = 1'b0;
  logic       rst;
  logic       REQ0, REQ1, GNT0, GNT1, BUSY, DONE, OUT_ID;
  logic [3:0] A0, A1, OUT;
  typedef struct packed {logic id; logic [3:0] val;} exp_t;
  exp_t q[$];
  int   gnt_log[$];
  int   done_cycles[$];
  int   tests = 0, fails = 0, cyc = 0;
  comp2_scheduler #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .REQ0(REQ0), .REQ1(REQ1), .A0(A0), .A1(A1),
    .GNT0(GNT0), .GNT1(GNT1), .BUSY(BUSY), .DONE(DONE), .OUT(OUT), .OUT_ID(OUT_ID)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Monitor: pops expected results on DONE and watches grant legality every cycle
  always @(negedge clk) begin
    if (!rst) begin
      tests++;
      if ((GNT0 && GNT1) || (BUSY && (GNT0 || GNT1))) begin
        fails++;
        $display("FAIL gnt_legal: got GNT0=%b GNT1=%b BUSY=%b, want one-hot grant only in IDLE", GNT0, GNT1, BUSY);
      end
      if (GNT0) gnt_log.push_back(0);
      if (GNT1) gnt_log.push_back(1);
      if (DONE) begin
        exp_t e;
        tests++;
        done_cycles.push_back(cyc);
        if (q.size() == 0) begin
          fails++;
          $display("FAIL done_unexpected: got DONE id=%0d out=%0d, want no DONE", OUT_ID, OUT);
        end else begin
          e = q.pop_front();
          if ({OUT_ID, OUT} !== e) begin
            fails++;
            $display("FAIL done_result: got id=%0d out=%0d, want id=%0d out=%0d", OUT_ID, OUT, e.id, e.val);
          end
        end
      end
    end
  end
  task automatic chk(input string n, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", n, act, exp);
    end
  endtask
  task automatic issue(input bit id, input logic [3:0] a, output int g);
    @(posedge clk);
    #1;
    if (id) begin A1 = a; REQ1 = 1'b1; end
    else begin A0 = a; REQ0 = 1'b1; end
    g = -1;
    for (int i = 0; i < 20 && g < 0; i++) begin
      @(negedge clk);
      if (id ? GNT1 : GNT0) g = cyc;
    end
    tests++;
    if (g < 0) begin
      fails++;
      $display("FAIL grant%0d: got no grant in 20 cycles, want grant", id);
    end
    @(posedge clk);
    #1;
    if (id) REQ1 = 1'b0;
    else REQ0 = 1'b0;
  endtask
  task automatic wait_idle();
    int i;
    for (i = 0; i < 40 && (q.size() != 0 || BUSY); i++) @(negedge clk);
    tests++;
    if (q.size() != 0 || BUSY) begin
      fails++;
      $display("FAIL idle_timeout: got %0d pending results busy=%b, want 0 pending idle", q.size(), BUSY);
    end
  endtask
  initial begin
    int g, g0, g1;
    logic [3:0] bnd_in [4];
    logic [3:0] bnd_out[4];
    bnd_in  = '{4'd0, 4'd1, 4'd8, 4'd15};
    bnd_out = '{4'd0, 4'd15, 4'd8, 4'd1};
    rst = 1'b1; REQ0 = 1'b0; REQ1 = 1'b0; A0 = '0; A1 = '0;
    #2;
    chk("rst_out", OUT, 0);
    chk("rst_out_id", OUT_ID, 0);
    chk("rst_done", DONE, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_gnt0_idle", GNT0, 0);
    REQ0 = 1'b1;
    #1;
    chk("rst_gnt0_follows", GNT0, 1);
    REQ0 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    // single request, latency
    q.push_back('{1'b0, 4'b1010});
    issue(0, 4'b0110, g);
    chk("busy_after_grant", BUSY, 1);
    wait_idle();
    chk("latency", done_cycles[$] - g, 5);
    // boundary operands on requester 1
    for (int i = 0; i < 4; i++) begin
      q.push_back('{1'b1, bnd_out[i]});
      issue(1, bnd_in[i], g);
      wait_idle();
    end
    // tie with both requests held continuously
    @(posedge clk);
    #1;
    gnt_log.delete();
    done_cycles.delete();
    q.push_back('{1'b0, 4'd13});
    q.push_back('{1'b1, 4'd11});
    q.push_back('{1'b0, 4'd13});
    q.push_back('{1'b1, 4'd11});
    A0 = 4'd3; A1 = 4'd5; REQ0 = 1'b1; REQ1 = 1'b1;
    for (int i = 0; i < 60 && gnt_log.size() < 4; i++) @(posedge clk);
    #1;
    REQ0 = 1'b0; REQ1 = 1'b0;
    chk("tie_grant_count", gnt_log.size(), 4);
    wait_idle();
    for (int i = 0; i < 4 && i < gnt_log.size(); i++) chk($sformatf("tie_grant%0d", i), gnt_log[i], i % 2);
    for (int i = 1; i < 4 && i < done_cycles.size(); i++) chk($sformatf("tie_spacing%0d", i), done_cycles[i] - done_cycles[i-1], 6);
    // request while busy and operand change mid-op
    q.push_back('{1'b0, 4'd14});
    q.push_back('{1'b1, 4'd9});
    issue(0, 4'd2, g0);
    repeat (2) @(posedge clk);
    #1;
    A0 = 4'hF;
    issue(1, 4'd7, g1);
    chk("busy_req_grant_delay", g1 - g0, 6);
    wait_idle();
    chk("busy_out", OUT, 9);
    // reset during SHIFT
    issue(0, 4'd5, g);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_out", OUT, 0);
    chk("midrst_out_id", OUT_ID, 0);
    chk("midrst_busy", BUSY, 0);
    chk("midrst_done", DONE, 0);
    #1;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("midrst_no_done_out", OUT, 0);
    q.push_back('{1'b1, 4'd13});
    issue(1, 4'd3, g);
    wait_idle();
    chk("post_rst_out", OUT, 13);
    chk("post_rst_out_id", OUT_ID, 1);
    chk("scoreboard_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
